// File: rtl/qspi_flash_pkg.sv
// rtl/qspi_flash_pkg.sv - shared types and constants for the QSPI flash memory responder
//
// Purpose: FSM state encoding, flash command opcode, phase lengths and the
// helper that reorders the received nibble stream into a bus word.
// Ports: none (package).
package qspi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE,
        ST_GAP
    } state_e;

    localparam logic [7:0] CMD_QREAD    = 8'h6B;
    localparam int         CMD_BITS     = 8;
    localparam int         ADDR_BITS    = 24;
    localparam int         DATA_NIBBLES = 8;

    // The nibble stream arrives as {byte0, byte1, byte2, byte3} in flash order;
    // the bus wants byte0 in the least significant lane.
    function automatic logic [31:0] nibbles_to_word(input logic [31:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

endpackage

// File: rtl/qspi_shift_phy.sv
// rtl/qspi_shift_phy.sv - SPI clock generator and serial shifters for the QSPI responder
//
// Purpose: generates a mode-0 SPI clock at clk/2 while enabled, shifts the
// single-line output MSB-first, collects quad input nibbles and counts bits.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   load              load load_data/load_count and restart the bit counter
//   load_data[23:0]   left-aligned output bits (bit 23 goes out first)
//   load_count[4:0]   number of SPI clocks in the phase
//   en                run the SPI clock
//   io_di[3:0]        quad input lines
//   sclk              SPI clock
//   sout              current single-line output bit
//   bit_done          high on the clk edge that completes the last SPI clock
//   nibbles_next      collected nibbles including the one sampled this edge
import qspi_flash_pkg::*;

module qspi_shift_phy (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] load_data,
    input  logic [4:0]           load_count,
    input  logic                 en,
    input  logic [3:0]           io_di,
    output logic                 sclk,
    output logic                 sout,
    output logic                 bit_done,
    output logic [31:0]          nibbles_next
);

    logic                 sclk_q, sclk_d;
    logic [ADDR_BITS-1:0] sr_q, sr_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [27:0]          nib_q, nib_d;
    logic                 fall;

    // The falling SPI edge is the clk edge that ends a high half-cycle: input
    // is sampled and the next output bit is presented on the same edge.
    assign fall         = en && sclk_q;
    assign bit_done     = fall && (cnt_q == 5'd1);
    assign nibbles_next = {nib_q, io_di};
    assign sclk         = sclk_q;
    assign sout         = sr_q[ADDR_BITS-1];

    always_comb begin
        sclk_d = sclk_q;
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        nib_d  = nib_q;
        if (en && !sclk_q) begin
            sclk_d = 1'b1;
        end
        if (fall) begin
            sclk_d = 1'b0;
            sr_d   = {sr_q[ADDR_BITS-2:0], 1'b0};
            cnt_d  = cnt_q - 5'd1;
            nib_d  = {nib_q[23:0], io_di};
        end
        if (load) begin
            sclk_d = 1'b0;
            sr_d   = load_data;
            cnt_d  = load_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b0;
            sr_q   <= '0;
            cnt_q  <= '0;
            nib_q  <= '0;
        end else begin
            sclk_q <= sclk_d;
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            nib_q  <= nib_d;
        end
    end

endmodule

// File: rtl/qspi_flash_mem_responder.sv
// rtl/qspi_flash_mem_responder.sv - picorv32 memory-bus read responder backed by QSPI flash
//
// Purpose: answers each read on the native memory bus with one Quad Output
// Fast Read (0x6B) of 4 bytes; writes are acknowledged and dropped.
// Ports:
//   clk, rst                       system clock, asynchronous active-high reset
//   mem_valid/mem_addr/mem_wstrb   request (already decoded to the flash window)
//   mem_ready/mem_rdata            one-cycle acknowledge and read word
//   flash_csn/flash_sclk           chip select (active-low), SPI clock (mode 0)
//   flash_io_oe/do/di              per-line output enable, output and input data
import qspi_flash_pkg::*;

module qspi_flash_mem_responder #(
    parameter logic [23:0] FLASH_BASE   = 24'h100000,
    parameter int          DUMMY_CYCLES = 8,
    parameter int          CSN_GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        flash_csn,
    output logic        flash_sclk,
    output logic [3:0]  flash_io_oe,
    output logic [3:0]  flash_io_do,
    input  logic [3:0]  flash_io_di
);

    state_e               state_q, state_d;
    logic                 csn_q, csn_d;
    logic                 ready_q, ready_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 start_q, start_d;
    logic [7:0]           gap_q, gap_d;

    logic                 phy_load;
    logic [ADDR_BITS-1:0] phy_load_data;
    logic [4:0]           phy_load_count;
    logic                 phy_en;
    logic                 phy_sout;
    logic                 phy_bit_done;
    logic [31:0]          phy_nibbles;

    logic [ADDR_BITS-1:0] req_addr;
    logic                 unused_addr_bits;
    logic                 single_line;

    // Word-aligned offset plus base; the 24-bit sum wraps naturally.
    assign req_addr         = {mem_addr[23:2], 2'b00} + FLASH_BASE;
    assign unused_addr_bits = ^{mem_addr[31:24], mem_addr[1:0]};

    assign single_line = (state_q == ST_CMD) || (state_q == ST_ADDR);
    assign flash_io_oe = single_line ? 4'b0001 : 4'b0000;
    assign flash_io_do = single_line ? {3'b000, phy_sout} : 4'b0000;
    assign flash_csn   = csn_q;
    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;

    qspi_shift_phy u_phy (
        .clk          (clk),
        .rst          (rst),
        .load         (phy_load),
        .load_data    (phy_load_data),
        .load_count   (phy_load_count),
        .en           (phy_en),
        .io_di        (flash_io_di),
        .sclk         (flash_sclk),
        .sout         (phy_sout),
        .bit_done     (phy_bit_done),
        .nibbles_next (phy_nibbles)
    );

    always_comb begin
        state_d        = state_q;
        csn_d          = csn_q;
        ready_d        = 1'b0;
        rdata_d        = rdata_q;
        addr_d         = addr_q;
        start_d        = 1'b0;
        gap_d          = gap_q;
        phy_load       = 1'b0;
        phy_load_data  = '0;
        phy_load_count = '0;
        phy_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                csn_d = 1'b1;
                if (mem_valid) begin
                    if (mem_wstrb != 4'b0000) begin
                        ready_d = 1'b1;
                        rdata_d = '0;
                        gap_d   = 8'(CSN_GAP - 1);
                        state_d = ST_GAP;
                    end else begin
                        addr_d         = req_addr;
                        csn_d          = 1'b0;
                        start_d        = 1'b1;
                        phy_load       = 1'b1;
                        phy_load_data  = {CMD_QREAD, 16'h0000};
                        phy_load_count = 5'(CMD_BITS);
                        state_d        = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                // First cycle after csn falls is a setup cycle with sclk held low.
                phy_en = !start_q;
                if (phy_bit_done) begin
                    phy_load       = 1'b1;
                    phy_load_data  = addr_q;
                    phy_load_count = 5'(ADDR_BITS);
                    state_d        = ST_ADDR;
                end
            end
            ST_ADDR: begin
                phy_en = 1'b1;
                if (phy_bit_done) begin
                    phy_load       = 1'b1;
                    phy_load_count = 5'(DUMMY_CYCLES);
                    state_d        = ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                phy_en = 1'b1;
                if (phy_bit_done) begin
                    phy_load       = 1'b1;
                    phy_load_count = 5'(DATA_NIBBLES);
                    state_d        = ST_DATA;
                end
            end
            ST_DATA: begin
                phy_en = 1'b1;
                if (phy_bit_done) begin
                    csn_d   = 1'b1;
                    state_d = ST_DONE;
                    // An abandoned request still finishes on the wire but is not acknowledged.
                    if (mem_valid) begin
                        ready_d = 1'b1;
                        rdata_d = nibbles_to_word(phy_nibbles);
                    end
                end
            end
            ST_DONE: begin
                gap_d   = 8'(CSN_GAP - 1);
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            csn_q   <= 1'b1;
            ready_q <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            start_q <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            csn_q   <= csn_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: doc/qspi_flash_mem_responder.md
Name: qspi_flash_mem_responder

Overview:
Read-only responder on the picorv32 native memory bus, serving instruction and data fetches from external QSPI flash. It answers each mem_valid/mem_ready request with one Quad Output Fast Read (0x6B) of 4 bytes. The top level decodes the flash window (mem_addr[31:28]==4'h1) and gates mem_valid into this block. The QSPI pins are tristated outside the block via io_oe/io_do/io_di.

Parameters:
FLASH_BASE, 24'h100000, byte offset added to the bus word address (firmware sits 1 MB into flash)
DUMMY_CYCLES, 8, SPI clocks between the address and data phases
CSN_GAP, 2, minimum clk cycles csn stays high between transactions (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
mem_valid  in  1  request valid, already qualified by the flash address decode
mem_addr  in  32  byte address; [23:2] used, [1:0] ignored
mem_wstrb  in  4  nonzero means write
mem_ready  out  1  one-cycle acknowledge
mem_rdata  out  32  read data, valid while mem_ready=1
flash_csn  out  1  chip select, active-low
flash_sclk  out  1  SPI clock, mode 0
flash_io_oe  out  4  per-line output enable
flash_io_do  out  4  output data
flash_io_di  in  4  input data

Behaviour:
- Reset (async, rst=1): state IDLE, flash_csn=1, flash_sclk=0, flash_io_oe=0, flash_io_do=0, mem_ready=0, mem_rdata=0. Reset mid-transfer aborts immediately: csn goes high, no mem_ready.
- States: IDLE -> CMD (8 SPI clk) -> ADDR (24) -> DUMMY (DUMMY_CYCLES) -> DATA (8) -> DONE -> GAP -> IDLE.
- SPI clock = clk/2. Each SPI bit takes a low half-cycle and then a high half-cycle, one clk each.
  - Outputs change only while sclk is low.
  - flash_io_di is sampled on the clk edge that ends the high half (the falling sclk edge).
- IDLE:
  - mem_valid=1 and mem_wstrb!=0: write is ignored. mem_ready=1 on the next cycle, mem_rdata=0, csn stays high, then go to GAP.
  - mem_valid=1 and mem_wstrb==0: latch flash address = {mem_addr[23:2],2'b00} + FLASH_BASE (mod 2^24). Drive csn=0 and enter CMD.
- CMD/ADDR: single-line, MSB-first on io_do[0], io_oe=4'b0001. CMD sends 8'h6B, ADDR sends the 24-bit address.
- DUMMY/DATA: io_oe=4'b0000.
- DATA: 8 nibbles, nibble k taken from io_di[3:0].
  - Even nibble = high half of a byte.
  - Byte n (n=0..3, flash order) goes to mem_rdata[8n+7:8n], i.e. little-endian.
- DONE: csn=1, sclk=0. mem_ready=1 for exactly one cycle with the assembled mem_rdata, but only if mem_valid is still 1. If mem_valid has dropped, the data is discarded and mem_ready stays 0.
- GAP: csn held high CSN_GAP cycles. New requests are accepted only in IDLE.
- Latency (defaults): mem_ready is high in the 98th cycle after the clk edge that samples mem_valid in IDLE. That is 1 setup cycle + 48 SPI clocks x 2 + 1.
- Back-to-back requests: minimum turnaround is 98 + CSN_GAP + 1 cycles.
- mem_rdata holds its last value outside mem_ready; consumers must qualify it with mem_ready.
- Address wrap: FLASH_BASE plus the offset overflowing 24 bits wraps to 0.

Decomposition:
- Shared package qspi_flash_pkg:
  - state enum;
  - CMD_QREAD=8'h6B;
  - CMD_BITS=8, ADDR_BITS=24, DATA_NIBBLES=8.
- One natural sub-module, qspi_shift_phy, owns:
  - the sclk toggle and half-phase flag;
  - the output shift register and the nibble input shift register;
  - the bit counter with a load/count/done interface.
- The FSM and bus handshake stay in the top module.

Test Plan:
- Read mem_addr=32'h1000_0004, flash model returns EF BE AD DE. Required:
  - io_do[0] carries 0x6B, then 0x100004, MSB-first;
  - 8 dummy clocks;
  - mem_ready high one cycle, 98 cycles after acceptance, with mem_rdata=32'hDEADBEEF;
  - csn high afterwards.
- mem_addr=32'h1000_0007 -> flash address 0x100004 on the wire (low bits ignored).
- Write with mem_wstrb=4'hF -> mem_ready on the next cycle, mem_rdata=0, csn never asserted, sclk never toggles.
- Back-to-back reads to 0x1000_0000 and 0x1000_0004 with mem_valid held. Required:
  - csn high for >=2 cycles between the reads;
  - both words correct;
  - exactly one ready pulse each.
- rst pulsed during the DATA phase -> csn=1, sclk=0, oe=0 asynchronously, no mem_ready. A later read to 0x1000_0000 completes correctly.
- mem_valid dropped during ADDR -> transfer completes on the wire, mem_ready never asserted, block returns to IDLE.
